// File: rtl/axil_mem_slave.sv
// ---------------------------------------------------------------------------
// axil_mem_slave
//   AXI4-Lite slave memory with per-byte write strobes, configurable read
//   latency and a backdoor word-preload port. Write and read channels are
//   served by independent state machines and run fully concurrently.
//
// Build option:
//   AXIL_MEM_SLVERR_EN  defined     : out-of-range accesses answer SLVERR
//                                     (2'b10); writes store nothing, reads
//                                     return zero.
//                       not defined : address aliases modulo DEPTH, every
//                                     response is OKAY.
//
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   S_AXI_AW*  (ADDR/VALID/READY) write address channel
//   S_AXI_W*   (DATA/STRB/VALID/READY) write data channel
//   S_AXI_B*   (RESP/VALID/READY) write response channel
//   S_AXI_AR*  (ADDR/VALID/READY) read address channel
//   S_AXI_R*   (DATA/RESP/VALID/READY) read data channel
//   BD_WE/BD_ADDR/BD_WDATA        backdoor full-word write request
//   BD_ACK                        one-cycle pulse: backdoor write committed
// ---------------------------------------------------------------------------
module axil_mem_slave #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,

    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,

    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,

    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,

    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,

    input  logic                BD_WE,
    input  logic [ADDR_W-1:0]   BD_ADDR,
    input  logic [DATA_W-1:0]   BD_WDATA,
    output logic                BD_ACK
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA}   rstate_t;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (LSB + IDX_W)) == '0);
    endfunction

    // Truncation to IDX_W bits gives the modulo-DEPTH alias for free.
    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // READYs stay low until the first edge after reset release.
    logic r_rdy_en;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t           r_wstate, w_wstate_nxt;
    logic              r_aw_got, r_w_got;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [1:0]        r_bresp;
    logic              r_bd_ack;
    logic              w_aw_hs, w_w_hs, w_commit, w_wr_en, w_bd_ok;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_wstate <= W_IDLE;
        else          r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        w_aw_hs       = 1'b0;
        w_w_hs        = 1'b0;
        w_commit      = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                S_AXI_AWREADY = r_rdy_en && !r_aw_got;
                S_AXI_WREADY  = r_rdy_en && !r_w_got;
                w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
                w_w_hs        = S_AXI_WVALID && S_AXI_WREADY;
                if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs))
                    w_wstate_nxt = W_COMMIT;
            end
            W_COMMIT: begin
                w_commit     = 1'b1;
                w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

`ifdef AXIL_MEM_SLVERR_EN
    assign w_wr_en = w_commit && f_in_range(r_awaddr);
`else
    assign w_wr_en = w_commit;
`endif

    // The AXI commit owns the memory write port; a colliding backdoor
    // request is dropped without ACK and the caller retries.
    assign w_bd_ok = BD_WE && !w_commit && f_in_range(BD_ADDR);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdy_en <= 1'b0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= 2'b00;
            r_bd_ack <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_bd_ack <= w_bd_ok;
            if (w_aw_hs) begin
                r_aw_got <= 1'b1;
                r_awaddr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_w_got <= 1'b1;
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
`ifdef AXIL_MEM_SLVERR_EN
                r_bresp  <= f_in_range(r_awaddr) ? 2'b00 : 2'b10;
`else
                r_bresp  <= 2'b00;
`endif
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive
    // ARESETn.
    always_ff @(posedge ACLK) begin
        if (w_wr_en) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (r_wstrb[i])
                    r_mem[f_index(r_awaddr)][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
        if (w_bd_ok)
            r_mem[f_index(BD_ADDR)] <= BD_WDATA;
    end

    assign S_AXI_BRESP = r_bresp;
    assign BD_ACK      = r_bd_ack;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t           r_rstate, w_rstate_nxt;
    logic [CNT_W-1:0]  r_rcnt;
    logic [ADDR_W-1:0] r_araddr;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rvalid;
    logic              w_ar_hs, w_rd_sample;
    logic [ADDR_W-1:0] w_rd_addr;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    // Memory is sampled on the edge that ends the latency count; RVALID is
    // registered one edge later, giving AR-handshake-to-RVALID = RD_LAT.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        S_AXI_ARREADY = 1'b0;
        w_ar_hs       = 1'b0;
        w_rd_sample   = 1'b0;
        w_rd_addr     = r_araddr;
        unique case (r_rstate)
            R_IDLE: begin
                S_AXI_ARREADY = r_rdy_en;
                w_ar_hs       = S_AXI_ARVALID && r_rdy_en;
                w_rd_addr     = S_AXI_ARADDR;
                if (w_ar_hs) begin
                    if (RD_LAT == 1) begin
                        w_rd_sample  = 1'b1;
                        w_rstate_nxt = R_DATA;
                    end else begin
                        w_rstate_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == CNT_W'(1)) begin
                    w_rd_sample  = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (r_rvalid && S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rcnt   <= '0;
            r_araddr <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            r_rvalid <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_araddr <= S_AXI_ARADDR;
                r_rcnt   <= CNT_W'(RD_LAT - 1);
            end else if (r_rstate == R_WAIT) begin
                r_rcnt <= r_rcnt - 1'b1;
            end
            if (w_rd_sample) begin
`ifdef AXIL_MEM_SLVERR_EN
                if (f_in_range(w_rd_addr)) begin
                    r_rdata <= r_mem[f_index(w_rd_addr)];
                    r_rresp <= 2'b00;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= 2'b10;
                end
`else
                r_rdata <= r_mem[f_index(w_rd_addr)];
                r_rresp <= 2'b00;
`endif
            end
            if (r_rstate == R_DATA && !r_rvalid)
                r_rvalid <= 1'b1;
            else if (r_rvalid && S_AXI_RREADY)
                r_rvalid <= 1'b0;
        end
    end

    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RVALID = r_rvalid;

endmodule

// File: tb/tb_axil_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_mem_slave
//   Directed self-checking bench for axil_mem_slave (DEPTH=2048, RD_LAT=4,
//   BASE=0x0001_0000). Expected values are hand-computed constants; the
//   out-of-range expectations follow AXIL_MEM_SLVERR_EN.
// ---------------------------------------------------------------------------
module tb_axil_mem_slave;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned DEP  = 2048;
    localparam int unsigned LAT  = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AW-1:0] S_AXI_ARADDR = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;
    logic          BD_WE = 1'b0;
    logic [AW-1:0] BD_ADDR = '0;
    logic [DW-1:0] BD_WDATA = '0;
    logic          BD_ACK;

    axil_mem_slave #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .BASE_ADDR(BASE),
        .RD_LAT   (LAT)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .BD_WE        (BD_WE),
        .BD_ADDR      (BD_ADDR),
        .BD_WDATA     (BD_WDATA),
        .BD_ACK       (BD_ACK)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d, output logic ack);
        BD_WE    = 1'b1;
        BD_ADDR  = a;
        BD_WDATA = d;
        tick();
        BD_WE = 1'b0;
        ack   = BD_ACK;
        tick();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        aw_done = 1'b0;
        w_done  = 1'b0;
        resp    = 2'bxx;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (S_AXI_BVALID) begin
                resp = S_AXI_BRESP;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int lat);
        logic ok;
        ok  = 1'b0;
        d   = 'x;
        r   = 'x;
        lat = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = S_AXI_ARREADY;
            tick();
        end
        S_AXI_ARVALID = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (S_AXI_RVALID) begin
                lat = i;
                d   = S_AXI_RDATA;
                r   = S_AXI_RRESP;
                break;
            end
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ack;
        logic [31:0] rd;
        logic [1:0]  rr, br;
        int          lat;
        logic [1:0]  exp_oor_resp;
        logic [31:0] exp_w0, exp_oor_rdata;

`ifdef AXIL_MEM_SLVERR_EN
        exp_oor_resp  = 2'b10;
        exp_w0        = 32'h1111_1111;
        exp_oor_rdata = 32'h0000_0000;
`else
        exp_oor_resp  = 2'b00;
        exp_w0        = 32'hA5A5_A5A5;
        exp_oor_rdata = 32'hA5A5_A5A5;
`endif

        // Reset values
        repeat (2) tick();
        chk("rst_ctrl", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                         S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, BD_ACK}, 64'h0);
        chk("rst_rdata", S_AXI_RDATA, 64'h0);
        ARESETn = 1'b1;
        #2;
        chk("rdy_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'b000);
        tick();
        chk("rdy_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'b111);

        // Backdoor preload then AXI readback
        bd_write(BASE + 32'h1000, 32'hDEAD_BEEF, ack);
        chk("bd_ack", ack, 1);
        chk("bd_ack_pulse", BD_ACK, 0);
        bd_write(BASE + 32'h2000, 32'h5555_5555, ack);
        chk("bd_oor_noack", ack, 0);
        axi_read(BASE + 32'h1000, rd, rr, lat);
        chk("rd_bd_data", rd, 32'hDEAD_BEEF);
        chk("rd_bd_resp", rr, 2'b00);
        chk("rd_latency", lat, LAT);
        chk("rd_done_ctrl", {S_AXI_RVALID, S_AXI_ARREADY}, 64'b01);

        // AW first, W three cycles later, strobe 0101 onto all-ones word
        bd_write(BASE + 32'h20, 32'hFFFF_FFFF, ack);
        S_AXI_BREADY  = 1'b1;
        S_AXI_AWADDR  = BASE + 32'h20;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("aw_only_ctrl", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 64'b010);
        repeat (2) tick();
        S_AXI_WDATA  = 32'h1234_5678;
        S_AXI_WSTRB  = 4'b0101;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("split_b_not_yet", S_AXI_BVALID, 0);
        tick();
        chk("split_bvalid", S_AXI_BVALID, 1);
        chk("split_bresp", S_AXI_BRESP, 2'b00);
        tick();
        chk("split_after_b", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 64'b011);
        axi_read(BASE + 32'h20, rd, rr, lat);
        chk("split_readback", rd, 32'hFF34_FF78);

        // WSTRB=0: no change, still OKAY
        axi_write(BASE + 32'h20, 32'h0000_0000, 4'b0000, br);
        chk("strb0_bresp", br, 2'b00);
        axi_read(BASE + 32'h20, rd, rr, lat);
        chk("strb0_readback", rd, 32'hFF34_FF78);

        // W before AW
        bd_write(BASE + 32'h84, 32'h0000_0000, ack);
        S_AXI_WDATA  = 32'h1357_2468;
        S_AXI_WSTRB  = 4'b1000;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("w_only_ctrl", {S_AXI_AWREADY, S_AXI_WREADY}, 64'b10);
        S_AXI_AWADDR  = BASE + 32'h84;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tick();
        chk("w_first_bvalid", S_AXI_BVALID, 1);
        tick();
        axi_read(BASE + 32'h84, rd, rr, lat);
        chk("w_first_readback", rd, 32'h1300_0000);

        // Out-of-range write / read at BASE + DEPTH*4
        bd_write(BASE, 32'h1111_1111, ack);
        axi_write(BASE + 32'h2000, 32'hA5A5_A5A5, 4'b1111, br);
        chk("oor_bresp", br, exp_oor_resp);
        axi_read(BASE, rd, rr, lat);
        chk("oor_word0", rd, exp_w0);
        axi_read(BASE + 32'h2000, rd, rr, lat);
        chk("oor_rdata", rd, exp_oor_rdata);
        chk("oor_rresp", rr, exp_oor_resp);

        // Read sample (edge k+3) coincides with W_COMMIT; backdoor in commit cycle
        bd_write(BASE + 32'h40, 32'h0BAD_F00D, ack);
        S_AXI_RREADY  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = BASE + 32'h40;
        S_AXI_ARVALID = 1'b1;
        tick();                                   // k: AR handshake
        S_AXI_ARVALID = 1'b0;
        chk("conf_arready_low", S_AXI_ARREADY, 0);
        tick();                                   // k+1
        S_AXI_AWADDR  = BASE + 32'h40;
        S_AXI_WDATA   = 32'h600D_CAFE;
        S_AXI_WSTRB   = 4'b1111;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();                                   // k+2: AW+W handshake
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        BD_WE    = 1'b1;
        BD_ADDR  = BASE + 32'h40;
        BD_WDATA = 32'h7777_7777;
        tick();                                   // k+3: commit + sample
        BD_WE = 1'b0;
        chk("conf_bd_dropped", BD_ACK, 0);
        chk("conf_bvalid", S_AXI_BVALID, 1);
        chk("conf_rvalid_early", S_AXI_RVALID, 0);
        tick();                                   // k+4
        chk("conf_rvalid", S_AXI_RVALID, 1);
        chk("conf_old_data", S_AXI_RDATA, 32'h0BAD_F00D);
        chk("conf_b_done", S_AXI_BVALID, 0);
        tick();
        chk("conf_r_done", S_AXI_RVALID, 0);
        axi_read(BASE + 32'h40, rd, rr, lat);
        chk("conf_new_data", rd, 32'h600D_CAFE);

        // RREADY held low for 5 cycles with RVALID up
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARADDR  = BASE + 32'h1000;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_wait_rvalid", S_AXI_RVALID, 0);
        end
        tick();
        chk("bp_rvalid_on", S_AXI_RVALID, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
        end
        S_AXI_RREADY = 1'b1;
        tick();
        chk("bp_release", {S_AXI_RVALID, S_AXI_ARREADY}, 64'b01);

        // Reset while BVALID=1 and read in R_WAIT
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = BASE + 32'h80;
        S_AXI_WDATA   = 32'hCAFE_F00D;
        S_AXI_WSTRB   = 4'b1111;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        tick();
        chk("mid_bvalid", S_AXI_BVALID, 1);
        S_AXI_ARADDR  = BASE + 32'h80;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        tick();
        #2;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_immediate", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY,
                                  S_AXI_WREADY, S_AXI_ARREADY}, 64'b00000);
        tick();
        ARESETn = 1'b1;
        #2;
        chk("mid_rdy_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'b000);
        tick();
        chk("mid_rdy_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                   S_AXI_BVALID, S_AXI_RVALID}, 64'b11100);
        axi_read(BASE + 32'h80, rd, rr, lat);
        chk("mid_mem_kept_80", rd, 32'hCAFE_F00D);
        axi_read(BASE + 32'h20, rd, rr, lat);
        chk("mid_mem_kept_20", rd, 32'hFF34_FF78);
        axi_read(BASE + 32'h1000, rd, rr, lat);
        chk("mid_mem_kept_1000", rd, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
